// File: rtl/kbd_rtc_pkg.sv
// Shared definitions for the keyboard-driven RTC edit scheduler.
// Contents: PS/2 set-2 key codes, MODO and FSM encodings, BCD field limits,
// and helpers that return the min/max of a field for a given group.
package kbd_rtc_pkg;

    // Set-2 make codes of the keys that mean something to the scheduler
    localparam logic [7:0] KEY_H     = 8'h33;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_T     = 8'h2C;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ModoNormal = 2'd0,
        ModoHora   = 2'd1,
        ModoFecha  = 2'd2,
        ModoTimer  = 2'd3
    } modo_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEdit = 2'd1,
        StReq  = 2'd2,
        StWait = 2'd3
    } state_e;

    // CAMPO encoding: field2 is the most significant byte of the group
    localparam logic [1:0] CAMPO_F2 = 2'd0;
    localparam logic [1:0] CAMPO_F1 = 2'd1;
    localparam logic [1:0] CAMPO_F0 = 2'd2;

    // BCD limits
    localparam logic [7:0] BCD_ZERO   = 8'h00;
    localparam logic [7:0] BCD_ONE    = 8'h01;
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;
    localparam logic [7:0] DAY_MAX    = 8'h31;
    localparam logic [7:0] MONTH_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MAX   = 8'h99;

    // Day and month start at 01; everything else starts at 00
    function automatic logic [7:0] field_min(modo_e modo, logic [1:0] campo);
        if (modo == ModoFecha && campo != CAMPO_F0) begin
            return BCD_ONE;
        end
        return BCD_ZERO;
    endfunction

    function automatic logic [7:0] field_max(modo_e modo, logic [1:0] campo);
        if (modo == ModoFecha) begin
            case (campo)
                CAMPO_F2: return DAY_MAX;
                CAMPO_F1: return MONTH_MAX;
                default:  return YEAR_MAX;
            endcase
        end
        return (campo == CAMPO_F2) ? HOUR_MAX : MINSEC_MAX;
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational +1/-1 of one two-digit BCD byte with wrap between min and max.
// Ports:
//   val_i  current byte          inc_i / dec_i  step request (inc wins)
//   min_i  lowest legal value    max_i          highest legal value
//   val_o  stepped byte (val_i when no step requested)
// A value that is not valid BCD or lies outside [min,max] steps to min.
module bcd_step (
    input  logic [7:0] val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    output logic [7:0] val_o
);

    logic       in_range;
    logic [7:0] plus_one;
    logic [7:0] minus_one;

    // Valid BCD orders like binary, so range checks can compare bytes directly
    assign in_range = (val_i[7:4] <= 4'd9) && (val_i[3:0] <= 4'd9) &&
                      (val_i >= min_i) && (val_i <= max_i);

    always_comb begin
        plus_one  = (val_i[3:0] == 4'd9) ? {val_i[7:4] + 4'd1, 4'd0}
                                         : {val_i[7:4], val_i[3:0] + 4'd1};
        minus_one = (val_i[3:0] == 4'd0) ? {val_i[7:4] - 4'd1, 4'd9}
                                         : {val_i[7:4], val_i[3:0] - 4'd1};
        val_o = val_i;
        if (inc_i || dec_i) begin
            if (!in_range) begin
                val_o = min_i;
            end else if (inc_i) begin
                val_o = (val_i == max_i) ? min_i : plus_one;
            end else begin
                val_o = (val_i == min_i) ? max_i : minus_one;
            end
        end
    end

endmodule

// File: rtl/kbd_fifo.sv
// Small key-code FIFO with asynchronous active-low reset.
// Ports:
//   clk_i, rst_ni        clock, async reset (flushes the FIFO)
//   push_i, data_i       write strobe and code
//   pop_i                read strobe (ignored when empty)
//   data_o               head entry, valid while empty_o=0
//   empty_o              no entries
//   overflow_o           push while full without a pop; the code is dropped
// Depth must be a power of two so the pointers wrap naturally.
module kbd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == DepthCnt);
    assign do_pop     = pop_i && !empty_o;
    // When full, a simultaneous pop frees the slot the push lands in
    assign do_push    = push_i && (!full || do_pop);
    assign overflow_o = push_i && full && !do_pop;
    assign data_o     = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/kbd_rtc_scheduler.sv
// Keyboard edit session for the RTC: buffers released-key codes, decodes
// them as commands, edits a BCD group and hands it to the RTC write
// controller with a req/ack handshake guarded by a timeout.
// Ports:
//   Reloj, RST               clock, async active-low reset
//   KEY_CODE, KEY_STB        released-key code and its one-cycle strobe
//   RTC_HORA/FECHA/TIMER     current RTC groups, loaded when a group is opened
//   WR_ACK                   write controller done pulse
//   MODO, CAMPO, VALOR       edited group, selected field, edit buffer
//   WR_REQ, WR_GRUPO         write request level and group being written
//   ERR                      one-cycle pulse on FIFO overflow or ack timeout
module kbd_rtc_scheduler
    import kbd_rtc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        Reloj,
    input  logic        RST,
    input  logic [7:0]  KEY_CODE,
    input  logic        KEY_STB,
    input  logic [23:0] RTC_HORA,
    input  logic [23:0] RTC_FECHA,
    input  logic [23:0] RTC_TIMER,
    input  logic        WR_ACK,
    output logic [1:0]  MODO,
    output logic [1:0]  CAMPO,
    output logic [23:0] VALOR,
    output logic        WR_REQ,
    output logic [1:0]  WR_GRUPO,
    output logic        ERR
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    modo_e             modo_q, modo_d;
    logic [1:0]        campo_q, campo_d;
    logic [23:0]       valor_q, valor_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              fifo_empty;
    logic              fifo_overflow;
    logic              fifo_pop;
    logic [7:0]        key;
    logic [7:0]        field_sel;
    logic [7:0]        field_step;
    logic [23:0]       valor_stepped;
    logic              wr_req;

    // The FIFO is drained only while the user is navigating
    assign fifo_pop = ((state_q == StIdle) || (state_q == StEdit)) && !fifo_empty;

    kbd_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i      (Reloj),
        .rst_ni     (RST),
        .push_i     (KEY_STB),
        .data_i     (KEY_CODE),
        .pop_i      (fifo_pop),
        .data_o     (key),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    always_comb begin
        case (campo_q)
            CAMPO_F2: field_sel = valor_q[23:16];
            CAMPO_F1: field_sel = valor_q[15:8];
            CAMPO_F0: field_sel = valor_q[7:0];
            default:  field_sel = BCD_ZERO;
        endcase
    end

    bcd_step u_step (
        .val_i (field_sel),
        .inc_i (key == KEY_W),
        .dec_i (key == KEY_S),
        .min_i (field_min(modo_q, campo_q)),
        .max_i (field_max(modo_q, campo_q)),
        .val_o (field_step)
    );

    always_comb begin
        valor_stepped = valor_q;
        case (campo_q)
            CAMPO_F2: valor_stepped[23:16] = field_step;
            CAMPO_F1: valor_stepped[15:8]  = field_step;
            CAMPO_F0: valor_stepped[7:0]   = field_step;
            default:  valor_stepped = valor_q;
        endcase
    end

    // State register
    always_ff @(posedge Reloj or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            modo_q  <= ModoNormal;
            campo_q <= CAMPO_F2;
            valor_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
            campo_q <= campo_d;
            valor_q <= valor_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        modo_d  = modo_q;
        campo_d = campo_q;
        valor_d = valor_q;
        cnt_d   = cnt_q;
        err_d   = fifo_overflow;
        unique case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    case (key)
                        KEY_H: begin
                            state_d = StEdit;
                            modo_d  = ModoHora;
                            valor_d = RTC_HORA;
                            campo_d = CAMPO_F2;
                        end
                        KEY_F: begin
                            state_d = StEdit;
                            modo_d  = ModoFecha;
                            valor_d = RTC_FECHA;
                            campo_d = CAMPO_F2;
                        end
                        KEY_T: begin
                            state_d = StEdit;
                            modo_d  = ModoTimer;
                            valor_d = RTC_TIMER;
                            campo_d = CAMPO_F2;
                        end
                        default: ;
                    endcase
                end
            end
            StEdit: begin
                if (fifo_pop) begin
                    case (key)
                        KEY_D: campo_d = (campo_q == CAMPO_F0) ? CAMPO_F2 : campo_q + 2'd1;
                        KEY_A: campo_d = (campo_q == CAMPO_F2) ? CAMPO_F0 : campo_q - 2'd1;
                        KEY_W, KEY_S: valor_d = valor_stepped;
                        KEY_ESC: begin
                            state_d = StIdle;
                            modo_d  = ModoNormal;
                        end
                        KEY_ENTER: state_d = StReq;
                        default: ;
                    endcase
                end
            end
            StReq: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                // Ack wins over a coinciding timeout
                if (WR_ACK || (cnt_q == TIMEOUT_LAST)) begin
                    state_d = StIdle;
                    modo_d  = ModoNormal;
                    cnt_d   = '0;
                    if (!WR_ACK) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs; WR_REQ decodes the state so reset clears it asynchronously
    assign wr_req = (state_q == StReq) || (state_q == StWait);

    always_comb begin
        WR_REQ   = wr_req;
        WR_GRUPO = wr_req ? modo_q : ModoNormal;
        MODO     = modo_q;
        CAMPO    = campo_q;
        VALOR    = valor_q;
        ERR      = err_q;
    end

endmodule

// File: tb/tb_kbd_rtc_scheduler.sv
module tb_kbd_rtc_scheduler;

    logic        Reloj;
    logic        RST;
    logic [7:0]  KEY_CODE;
    logic        KEY_STB;
    logic [23:0] RTC_HORA;
    logic [23:0] RTC_FECHA;
    logic [23:0] RTC_TIMER;
    logic        WR_ACK;
    logic [1:0]  MODO;
    logic [1:0]  CAMPO;
    logic [23:0] VALOR;
    logic        WR_REQ;
    logic [1:0]  WR_GRUPO;
    logic        ERR;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt;

    localparam logic [7:0] K_H = 8'h33, K_F = 8'h2B, K_T = 8'h2C, K_W = 8'h1D, K_S = 8'h1B;
    localparam logic [7:0] K_A = 8'h1C, K_D = 8'h23, K_ENTER = 8'h5A, K_ESC = 8'h76;

    kbd_rtc_scheduler #(
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .Reloj     (Reloj),
        .RST       (RST),
        .KEY_CODE  (KEY_CODE),
        .KEY_STB   (KEY_STB),
        .RTC_HORA  (RTC_HORA),
        .RTC_FECHA (RTC_FECHA),
        .RTC_TIMER (RTC_TIMER),
        .WR_ACK    (WR_ACK),
        .MODO      (MODO),
        .CAMPO     (CAMPO),
        .VALOR     (VALOR),
        .WR_REQ    (WR_REQ),
        .WR_GRUPO  (WR_GRUPO),
        .ERR       (ERR)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one code, then let it be popped and take effect
    task automatic send_key(input logic [7:0] code);
        KEY_CODE = code;
        KEY_STB  = 1'b1;
        tick();
        KEY_STB  = 1'b0;
        tick();
    endtask

    logic [7:0] burst [5];

    initial begin
        RST = 1'b1;
        KEY_CODE = 8'h00;
        KEY_STB = 1'b0;
        WR_ACK = 1'b0;
        RTC_HORA = 24'h235958;
        RTC_FECHA = 24'h311299;
        RTC_TIMER = 24'h123456;
        #1 RST = 1'b0;
        tick();
        tick();
        check("rst_modo", 32'(MODO), 32'd0);
        check("rst_campo", 32'(CAMPO), 32'd0);
        check("rst_valor", 32'(VALOR), 32'h0);
        check("rst_wr_req", 32'(WR_REQ), 32'd0);
        check("rst_wr_grupo", 32'(WR_GRUPO), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        RST = 1'b1;
        tick();

        // Time group: hour and minute wrap upward
        send_key(K_H);
        check("h_modo", 32'(MODO), 32'd1);
        check("h_campo", 32'(CAMPO), 32'd0);
        check("h_valor", 32'(VALOR), 32'h235958);
        send_key(K_W);
        check("h_inc_hour", 32'(VALOR), 32'h005958);
        send_key(K_D);
        check("h_campo1", 32'(CAMPO), 32'd1);
        send_key(K_W);
        check("h_inc_min", 32'(VALOR), 32'h000058);
        send_key(K_ESC);
        check("esc_modo", 32'(MODO), 32'd0);
        check("esc_valor", 32'(VALOR), 32'h000058);

        // Date group: year, month wrap both ways, field cursor wrap
        send_key(K_F);
        check("f_modo", 32'(MODO), 32'd2);
        check("f_valor", 32'(VALOR), 32'h311299);
        send_key(K_D);
        send_key(K_D);
        check("f_campo2", 32'(CAMPO), 32'd2);
        send_key(K_W);
        check("f_inc_year", 32'(VALOR), 32'h311200);
        send_key(K_A);
        send_key(K_W);
        check("f_inc_month", 32'(VALOR), 32'h310100);
        send_key(K_S);
        check("f_dec_month", 32'(VALOR), 32'h311200);
        send_key(K_A);
        send_key(K_A);
        check("f_left_wrap", 32'(CAMPO), 32'd2);
        send_key(K_D);
        check("f_right_wrap", 32'(CAMPO), 32'd0);
        send_key(K_H);
        check("f_h_ignored", 32'(MODO), 32'd2);
        send_key(K_ESC);

        // Out-of-range hour forces minimum, then decrement wraps 00 -> 23
        RTC_HORA = 24'h240000;
        send_key(K_H);
        send_key(K_S);
        check("oor_force_min", 32'(VALOR), 32'h000000);
        send_key(K_S);
        check("dec_hour_wrap", 32'(VALOR), 32'h230000);
        send_key(K_ESC);

        // Timer write, ack 5 cycles after request rises
        send_key(K_T);
        check("t_valor", 32'(VALOR), 32'h123456);
        send_key(K_ENTER);
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) WR_ACK = 1'b1;
            if (WR_REQ) hi_cnt++;
            check("ack_wr_grupo", 32'(WR_GRUPO), 32'd3);
            tick();
        end
        WR_ACK = 1'b0;
        check("ack_req_cycles", 32'(hi_cnt), 32'd6);
        check("ack_req_low", 32'(WR_REQ), 32'd0);
        check("ack_modo", 32'(MODO), 32'd0);
        check("ack_err", 32'(ERR), 32'd0);

        // Timeout: no ack, 1 REQ + 16 WAIT cycles, then ERR pulse
        RTC_HORA = 24'h101010;
        send_key(K_H);
        send_key(K_ENTER);
        check("to_wr_grupo", 32'(WR_GRUPO), 32'd1);
        hi_cnt = 0;
        for (int g = 0; g < 40 && WR_REQ; g++) begin
            hi_cnt++;
            tick();
        end
        check("to_req_cycles", 32'(hi_cnt), 32'd17);
        check("to_err", 32'(ERR), 32'd1);
        check("to_modo", 32'(MODO), 32'd0);
        tick();
        check("to_err_pulse", 32'(ERR), 32'd0);

        // Overflow: 5 pushes while waiting, 5th dropped, first 4 replayed in order
        RTC_HORA = 24'h000000;
        send_key(K_H);
        send_key(K_ENTER);
        burst[0] = K_H; burst[1] = K_D; burst[2] = K_W; burst[3] = K_W; burst[4] = K_D;
        for (int i = 0; i < 5; i++) begin
            KEY_CODE = burst[i];
            KEY_STB  = 1'b1;
            tick();
        end
        KEY_STB = 1'b0;
        check("ovf_err", 32'(ERR), 32'd1);
        tick();
        check("ovf_err_pulse", 32'(ERR), 32'd0);
        WR_ACK = 1'b1;
        tick();
        WR_ACK = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("ovf_modo", 32'(MODO), 32'd1);
        check("ovf_campo", 32'(CAMPO), 32'd1);
        check("ovf_valor", 32'(VALOR), 32'h000200);
        check("ovf_no_err", 32'(ERR), 32'd0);

        // Reset in the middle of a handshake with a key queued
        send_key(K_ENTER);
        check("mid_wr_req", 32'(WR_REQ), 32'd1);
        KEY_CODE = K_F;
        KEY_STB  = 1'b1;
        tick();
        KEY_STB  = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("arst_wr_req", 32'(WR_REQ), 32'd0);
        check("arst_modo", 32'(MODO), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_modo", 32'(MODO), 32'd0);
        check("post_rst_valor", 32'(VALOR), 32'h0);
        check("post_rst_wr_req", 32'(WR_REQ), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
